adas_actuator_ctrl: RTL and testbench

Vehicle-side consumer of the ADAS gas/brake command pair. Each control tick, it decodes the two command bits into a pedal intent. It then ramps throttle and brake duty levels with a hard interlock, so the two are never both nonzero. Free-running PWM outputs drive the actuators. The block sits between the ADAS controller's gas/brake outputs and the throttle and brake drivers, and adds an immediate emergency-brake override.

---
 rtl/adas_actuator_ctrl.sv | 124 ++++++++++++
 tb/tb_adas_actuator_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/adas_actuator_ctrl.sv
// ADAS gas/brake actuator controller: tick-gated pedal intent decode, interlocked
// throttle/brake duty ramps, emergency-brake override and free-running PWM drive.
module adas_actuator_ctrl #(
  parameter int unsigned STEP    = 8,
  parameter int unsigned THR_MAX = 200,
  parameter int unsigned BRK_MAX = 240
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       timer_trick_i,
  input  logic       mode_i,
  input  logic       gas_i,
  input  logic       brake_i,
  input  logic       emerg_i,
  output logic [2:0] state_o,
  output logic [7:0] throttle_duty_o,
  output logic [7:0] brake_duty_o,
  output logic       throttle_pwm_o,
  output logic       brake_pwm_o
);
  localparam int NUM_CH = 2;
  localparam logic [8:0] STEP_1X  = 9'(STEP);
  localparam logic [8:0] STEP_2X  = 9'(2 * STEP);
  localparam logic [8:0] THR_CEIL = 9'(THR_MAX);
  localparam logic [8:0] BRK_CEIL = 9'(BRK_MAX);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COAST = 3'd1,
    S_ACCEL = 3'd2,
    S_BRAKE = 3'd3,
    S_HOLD  = 3'd4,
    S_EMERG = 3'd5
  } state_e;

  function automatic logic [7:0] sat_sub(input logic [7:0] v, input logic [8:0] dec);
    return (dec > {1'b0, v}) ? 8'd0 : 8'({1'b0, v} - dec);
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] v, input logic [8:0] inc,
                                         input logic [8:0] ceil);
    logic [8:0] r;
    r = {1'b0, v} + inc;
    return (r > ceil) ? ceil[7:0] : r[7:0];
  endfunction

  state_e     state_q, cmd_d;
  logic [7:0] thr_q, brk_q;

  always_comb begin
    cmd_d = S_IDLE;
    if (mode_i) begin
      case ({gas_i, brake_i})
        2'b00:   cmd_d = S_COAST;
        2'b10:   cmd_d = S_ACCEL;
        2'b01:   cmd_d = S_BRAKE;
        default: cmd_d = S_HOLD;
      endcase
    end
  end

  // A pedal only rises once the opposing one has already reached zero,
  // which keeps the pair mutually exclusive on every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      thr_q   <= '0;
      brk_q   <= '0;
    end else if (emerg_i) begin
      state_q <= S_EMERG;
      thr_q   <= '0;
      brk_q   <= BRK_CEIL[7:0];
    end else if (timer_trick_i) begin
      state_q <= cmd_d;
      case (cmd_d)
        S_COAST: begin
          thr_q <= sat_sub(thr_q, STEP_1X);
          brk_q <= sat_sub(brk_q, STEP_1X);
        end
        S_ACCEL: begin
          brk_q <= sat_sub(brk_q, STEP_1X);
          if (brk_q == 8'd0) thr_q <= sat_add(thr_q, STEP_1X, THR_CEIL);
        end
        S_BRAKE: begin
          thr_q <= sat_sub(thr_q, STEP_2X);
          if (thr_q == 8'd0) brk_q <= sat_add(brk_q, STEP_1X, BRK_CEIL);
        end
        S_HOLD: brk_q <= sat_sub(brk_q, STEP_1X);
        default: begin
          thr_q <= '0;
          brk_q <= '0;
        end
      endcase
    end
  end

  assign state_o         = state_q;
  assign throttle_duty_o = thr_q;
  assign brake_duty_o    = brk_q;

  // PWM: channel 0 throttle, channel 1 brake; shadows reload only at the wrap.
  logic [7:0]              cnt_q;
  logic [NUM_CH-1:0][7:0]  duty, shadow_q;
  logic [NUM_CH-1:0]       pwm_q;

  assign duty = {brk_q, thr_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      pwm_q    <= '0;
    end else begin
      cnt_q <= cnt_q + 8'd1;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (cnt_q == 8'hFF) shadow_q[ch] <= duty[ch];
        pwm_q[ch] <= (cnt_q < shadow_q[ch]);
      end
    end
  end

  assign throttle_pwm_o = pwm_q[0];
  assign brake_pwm_o    = pwm_q[1];
endmodule

// File: tb/tb_adas_actuator_ctrl.sv
// Bench for adas_actuator_ctrl: table vectors, directed ramp/emergency/PWM sequences,
// and random stimulus against a cycle-level reference model.
module tb_adas_actuator_ctrl;
  localparam int STEP = 8, THR_MAX = 200, BRK_MAX = 240;

  logic       clk = 1'b0;
  logic       rst = 1'b0, tick = 1'b0, mode = 1'b0, gas = 1'b0, brk = 1'b0, emerg = 1'b0;
  logic [2:0] state;
  logic [7:0] thr_duty, brk_duty;
  logic       thr_pwm, brk_pwm;

  adas_actuator_ctrl #(.STEP(STEP), .THR_MAX(THR_MAX), .BRK_MAX(BRK_MAX)) dut (
    .clk(clk), .rst(rst), .timer_trick_i(tick), .mode_i(mode), .gas_i(gas),
    .brake_i(brk), .emerg_i(emerg), .state_o(state), .throttle_duty_o(thr_duty),
    .brake_duty_o(brk_duty), .throttle_pwm_o(thr_pwm), .brake_pwm_o(brk_pwm)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // Reference model: state code, duties, PWM counter, shadows, PWM outputs.
  int m_st = 0, m_thr = 0, m_brk = 0, m_cnt = 0, m_sht = 0, m_shb = 0, m_pt = 0, m_pb = 0;
  int dec[4] = '{1, 3, 2, 4};   // index {gas,brake}: 00 COAST, 01 BRAKE, 10 ACCEL, 11 HOLD

  function automatic int clamp(int x, int hi);
    return (x < 0) ? 0 : ((x > hi) ? hi : x);
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(bit r, bit t, bit m, bit g, bit b, bit e);
    int ns, nt, nb;
    rst = r; tick = t; mode = m; gas = g; brk = b; emerg = e;
    @(posedge clk);
    ns = m_st; nt = m_thr; nb = m_brk;
    if (e) begin
      ns = 5; nt = 0; nb = BRK_MAX;
    end else if (t) begin
      ns = m ? dec[{g, b}] : 0;
      case (ns)
        1: begin nt = clamp(m_thr - STEP, THR_MAX); nb = clamp(m_brk - STEP, BRK_MAX); end
        2: begin
          nb = clamp(m_brk - STEP, BRK_MAX);
          if (m_brk == 0) nt = clamp(m_thr + STEP, THR_MAX);
        end
        3: begin
          nt = clamp(m_thr - 2 * STEP, THR_MAX);
          if (m_thr == 0) nb = clamp(m_brk + STEP, BRK_MAX);
        end
        4: nb = clamp(m_brk - STEP, BRK_MAX);
        default: begin nt = 0; nb = 0; end
      endcase
    end
    m_pt = (m_cnt < m_sht) ? 1 : 0;
    m_pb = (m_cnt < m_shb) ? 1 : 0;
    if (m_cnt == 255) begin m_sht = m_thr; m_shb = m_brk; end
    m_cnt = (m_cnt + 1) % 256;
    m_st = ns; m_thr = nt; m_brk = nb;
    if (r) begin
      m_st = 0; m_thr = 0; m_brk = 0; m_cnt = 0; m_sht = 0; m_shb = 0; m_pt = 0; m_pb = 0;
    end
    #1;
    n_tests++;
    if (state !== 3'(m_st) || thr_duty !== 8'(m_thr) || brk_duty !== 8'(m_brk) ||
        thr_pwm !== m_pt[0] || brk_pwm !== m_pb[0]) begin
      n_fail++;
      $display("FAIL model: got st=%0d thr=%0d brk=%0d pt=%b pb=%b expected st=%0d thr=%0d brk=%0d pt=%0d pb=%0d",
               state, thr_duty, brk_duty, thr_pwm, brk_pwm, m_st, m_thr, m_brk, m_pt, m_pb);
    end
    n_tests++;
    if (thr_duty != 0 && brk_duty != 0) begin
      n_fail++;
      $display("FAIL interlock: got thr=%0d brk=%0d expected one of them 0", thr_duty, brk_duty);
    end
  endtask

  typedef struct {
    bit t, m, g, b, e;
    int st, thr, brk;
  } vec_t;

  vec_t tbl[14];
  int   hi, guard;

  initial begin
    tbl[0]  = '{1, 1, 1, 0, 0, 2, 8, 0};
    tbl[1]  = '{1, 1, 1, 0, 0, 2, 16, 0};
    tbl[2]  = '{1, 1, 0, 1, 0, 3, 0, 0};
    tbl[3]  = '{1, 1, 0, 1, 0, 3, 0, 8};
    tbl[4]  = '{1, 1, 1, 0, 0, 2, 0, 0};
    tbl[5]  = '{1, 1, 1, 0, 0, 2, 8, 0};
    tbl[6]  = '{1, 1, 1, 1, 0, 4, 8, 0};
    tbl[7]  = '{0, 1, 0, 1, 0, 4, 8, 0};
    tbl[8]  = '{0, 1, 0, 1, 1, 5, 0, 240};
    tbl[9]  = '{1, 1, 0, 1, 1, 5, 0, 240};
    tbl[10] = '{0, 1, 0, 0, 0, 5, 0, 240};
    tbl[11] = '{1, 1, 0, 0, 0, 1, 0, 232};
    tbl[12] = '{1, 0, 0, 0, 0, 0, 0, 0};
    tbl[13] = '{1, 1, 0, 0, 0, 1, 0, 0};

    // Reset with random inputs, then PWM must stay low for a full period.
    for (int i = 0; i < 2; i++)
      cyc(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    chk("rst_state", int'(state), 0);
    chk("rst_thr", int'(thr_duty), 0);
    chk("rst_brk", int'(brk_duty), 0);
    chk("rst_pwm", int'({thr_pwm, brk_pwm}), 0);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      hi += int'(thr_pwm) + int'(brk_pwm);
    end
    chk("rst_pwm_low_period", hi, 0);

    // Table vectors from a clean reset.
    cyc(1, 0, 0, 0, 0, 0);
    foreach (tbl[i]) begin
      cyc(0, tbl[i].t, tbl[i].m, tbl[i].g, tbl[i].b, tbl[i].e);
      chk($sformatf("tbl%0d_state", i), int'(state), tbl[i].st);
      chk($sformatf("tbl%0d_thr", i), int'(thr_duty), tbl[i].thr);
      chk($sformatf("tbl%0d_brk", i), int'(brk_duty), tbl[i].brk);
    end

    // Ramp up to the throttle ceiling.
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 30; k++) begin
      cyc(0, 1, 1, 1, 0, 0);
      chk($sformatf("ramp_thr_t%0d", k), int'(thr_duty), (8 * k > 200) ? 200 : 8 * k);
      chk("ramp_brk", int'(brk_duty), 0);
      chk("ramp_state", int'(state), 2);
    end

    // Reversal: throttle decays by 16 per tick before brake may rise.
    for (int k = 1; k <= 50; k++) begin
      cyc(0, 1, 1, 0, 1, 0);
      chk($sformatf("rev_thr_t%0d", k), int'(thr_duty), (200 - 16 * k < 0) ? 0 : 200 - 16 * k);
      chk($sformatf("rev_brk_t%0d", k), int'(brk_duty),
          (k <= 13) ? 0 : ((8 * (k - 13) > 240) ? 240 : 8 * (k - 13)));
    end

    // Emergency during ACCEL at throttle 96.
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 12; k++) cyc(0, 1, 1, 1, 0, 0);
    chk("emg_pre_thr", int'(thr_duty), 96);
    cyc(0, 0, 1, 1, 0, 1);
    chk("emg_thr", int'(thr_duty), 0);
    chk("emg_brk", int'(brk_duty), 240);
    chk("emg_state", int'(state), 5);
    for (int k = 0; k < 4; k++) begin
      cyc(0, k[0], 1, 1, 0, 1);
      chk("emg_hold_state", int'(state), 5);
      chk("emg_hold_brk", int'(brk_duty), 240);
    end
    cyc(0, 1, 1, 0, 0, 0);
    chk("emg_exit_state", int'(state), 1);
    chk("emg_exit_brk", int'(brk_duty), 232);

    // PWM period counts with a duty change mid-period.
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) cyc(0, 1, 1, 1, 0, 0);
    guard = 0;
    while (m_cnt != 0 && guard < 300) begin cyc(0, 0, 1, 1, 0, 0); guard++; end
    chk("pwm_align_timeout", int'(guard < 300), 1);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      cyc(0, (m_cnt >= 100 && m_cnt < 108), 1, 1, 0, 0);
      hi += int'(thr_pwm);
    end
    chk("pwm_period_64", hi, 64);
    chk("pwm_new_duty", int'(thr_duty), 128);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      cyc(0, 0, 1, 1, 0, 0);
      hi += int'(thr_pwm);
    end
    chk("pwm_period_128", hi, 128);

    // HOLD freezes throttle; command changes without a tick are ignored.
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) cyc(0, 1, 1, 1, 0, 0);
    for (int k = 0; k < 10; k++) begin
      cyc(0, 1, 1, 1, 1, 0);
      chk("hold_thr", int'(thr_duty), 80);
      chk("hold_state", int'(state), 4);
    end
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("notick_state", int'(state), 4);
    chk("notick_thr", int'(thr_duty), 80);
    cyc(0, 1, 0, 1, 0, 0);
    chk("mode0_state", int'(state), 0);
    chk("mode0_thr", int'(thr_duty), 0);

    // Randomized stimulus against the model.
    for (int i = 0; i < 4000; i++)
      cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) != 0),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
